// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: ALU ctrl codes, aluop classes,
// R-type funct codes and the skid-buffer state type.
package alu_pkg;

  localparam logic [2:0] CTRL_AND  = 3'b000;
  localparam logic [2:0] CTRL_OR   = 3'b001;
  localparam logic [2:0] CTRL_ADD  = 3'b010;
  localparam logic [2:0] CTRL_PASS = 3'b011;
  localparam logic [2:0] CTRL_SUB  = 3'b110;
  localparam logic [2:0] CTRL_XOR  = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_PASS  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;

  // Encoding equals the number of buffered entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: main-decoder aluop plus R-type funct
// to a 3-bit ALU ctrl code, flagging unsupported funct values.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] ctrl,
  output logic       ill
);

  always_comb begin
    ctrl = CTRL_PASS;
    ill  = 1'b0;
    case (aluop)
      ALUOP_ADD:  ctrl = CTRL_ADD;
      ALUOP_SUB:  ctrl = CTRL_SUB;
      ALUOP_PASS: ctrl = CTRL_PASS;
      default: begin
        case (funct)
          FUNCT_ADD: ctrl = CTRL_ADD;
          FUNCT_SUB: ctrl = CTRL_SUB;
          FUNCT_AND: ctrl = CTRL_AND;
          FUNCT_OR:  ctrl = CTRL_OR;
          FUNCT_XOR: ctrl = CTRL_XOR;
          default: begin
            // Unknown R-type: pass data1 through and tell EX it is illegal.
            ctrl = CTRL_PASS;
            ill  = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue stage: decodes ID beats and holds them in a 2-entry in-order
// skid buffer feeding EX. Optional operand forwarding under ALU_ISSUE_FWD_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [RD_W-1:0]   rd,
`ifdef ALU_ISSUE_FWD_EN
  input  logic [RD_W-1:0]   rs_a,
  input  logic [RD_W-1:0]   rs_b,
  input  logic              fwd_valid,
  input  logic [RD_W-1:0]   fwd_rd,
  input  logic [DATA_W-1:0] fwd_data,
`endif
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [RD_W-1:0]   out_rd,
  output logic              ill_funct,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat moves when valid && ready on a rising edge. in_ready
  // depends only on buffer state and rst; out_valid only on buffer state.

  skid_state_t       state;
  logic [2:0]        dec_ctrl;
  logic              dec_ill;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [2:0]        sk_ctrl;
  logic [DATA_W-1:0] sk_a;
  logic [DATA_W-1:0] sk_b;
  logic [RD_W-1:0]   sk_rd;
  logic              sk_ill;
  logic              accept;
  logic              pop;

  alu_ctrl_dec u_dec (
    .aluop (aluop),
    .funct (funct),
    .ctrl  (dec_ctrl),
    .ill   (dec_ill)
  );

  always_comb begin
    a_in = op_a;
    b_in = op_b;
`ifdef ALU_ISSUE_FWD_EN
    // r0 is hard-wired zero, so a write to it never forwards.
    if (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs_a)) a_in = fwd_data;
    if (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs_b)) b_in = fwd_data;
`endif
  end

  assign in_ready  = (state != ST_TWO) && !rst;
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign dbg_state = state;

  // The head entry registers are the EX-facing outputs; sk_* is the second slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      alu_ctrl  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      out_rd    <= '0;
      ill_funct <= 1'b0;
      sk_ctrl   <= '0;
      sk_a      <= '0;
      sk_b      <= '0;
      sk_rd     <= '0;
      sk_ill    <= 1'b0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            alu_ctrl  <= dec_ctrl;
            alu_a     <= a_in;
            alu_b     <= b_in;
            out_rd    <= rd;
            ill_funct <= dec_ill;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            alu_ctrl  <= dec_ctrl;
            alu_a     <= a_in;
            alu_b     <= b_in;
            out_rd    <= rd;
            ill_funct <= dec_ill;
          end else if (accept) begin
            sk_ctrl <= dec_ctrl;
            sk_a    <= a_in;
            sk_b    <= b_in;
            sk_rd   <= rd;
            sk_ill  <= dec_ill;
            state   <= ST_TWO;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            alu_ctrl  <= sk_ctrl;
            alu_a     <= sk_a;
            alu_b     <= sk_b;
            out_rd    <= sk_rd;
            ill_funct <= sk_ill;
            state     <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios then random
// traffic, checked against a queue-based model of the issue buffer.
module tb_alu_issue_ctrl;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int EW     = 3 + 1 + RD_W + 2 * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        aluop;
  logic [5:0]        funct;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [RD_W-1:0]   rd;
`ifdef ALU_ISSUE_FWD_EN
  logic [RD_W-1:0]   rs_a;
  logic [RD_W-1:0]   rs_b;
  logic              fwd_valid;
  logic [RD_W-1:0]   fwd_rd;
  logic [DATA_W-1:0] fwd_data;
`endif
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [RD_W-1:0]   out_rd;
  logic              ill_funct;
  logic [1:0]        dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: entries the buffer should hold, oldest first, packed as
  // {ctrl, ill, rd, a, b}. last_shown tracks what the held payload must be.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_shown;

  alu_issue_ctrl #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .funct     (funct),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd        (rd),
`ifdef ALU_ISSUE_FWD_EN
    .rs_a      (rs_a),
    .rs_b      (rs_b),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
`endif
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .out_rd    (out_rd),
    .ill_funct (ill_funct),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_dec(input logic [1:0] aop, input logic [5:0] fn);
    case (aop)
      2'b00: return {1'b0, 3'b010};
      2'b01: return {1'b0, 3'b110};
      2'b11: return {1'b0, 3'b011};
      default: begin
        case (fn)
          6'b100000: return {1'b0, 3'b010};
          6'b100010: return {1'b0, 3'b110};
          6'b100100: return {1'b0, 3'b000};
          6'b100101: return {1'b0, 3'b001};
          6'b100110: return {1'b0, 3'b111};
          default:   return {1'b1, 3'b011};
        endcase
      end
    endcase
  endfunction

  function automatic logic [EW-1:0] offered_entry();
    logic [3:0]        d;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    d = ref_dec(aluop, funct);
    a = op_a;
    b = op_b;
`ifdef ALU_ISSUE_FWD_EN
    if (fwd_valid && fwd_rd != 0 && fwd_rd == rs_a) a = fwd_data;
    if (fwd_valid && fwd_rd != 0 && fwd_rd == rs_b) b = fwd_data;
`endif
    return {d[2:0], d[3], rd, a, b};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge with inputs already set: checks in_ready,
  // advances one clock, updates the model, then checks the outputs.
  task automatic step();
    logic          exp_ir;
    logic          exp_ov;
    logic          acc;
    logic          pp;
    logic [EW-1:0] ent;
    #1;
    exp_ir = !rst && (exp_q.size() < 2);
    exp_ov = (exp_q.size() != 0);
    chk("in_ready", in_ready, exp_ir);
    acc = in_valid && exp_ir;
    pp  = exp_ov && out_ready;
    ent = offered_entry();
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      last_shown = '0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ent);
    end
    if (exp_q.size() != 0) last_shown = exp_q[0];
    @(negedge clk);
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("state", dbg_state, exp_q.size());
    chk("payload", {alu_ctrl, ill_funct, out_rd, alu_a, alu_b}, last_shown);
  endtask

  task automatic set_beat(input logic v, input logic [1:0] aop, input logic [5:0] fn,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [RD_W-1:0] r);
    in_valid = v;
    aluop    = aop;
    funct    = fn;
    op_a     = a;
    op_b     = b;
    rd       = r;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] legal_fn[5];
    legal_fn[0] = 6'b100000;
    legal_fn[1] = 6'b100010;
    legal_fn[2] = 6'b100100;
    legal_fn[3] = 6'b100101;
    legal_fn[4] = 6'b100110;
    last_shown = '0;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    set_beat(1'b0, 2'b00, 6'd0, '0, '0, '0);
`ifdef ALU_ISSUE_FWD_EN
    rs_a = '0; rs_b = '0; fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
`endif
    @(negedge clk);

    // Reset: outputs zero, in_ready held low while rst is high.
    step();
    step();
    rst = 1'b0;
    chk("reset_zero", {out_valid, alu_ctrl, alu_a, alu_b, out_rd, ill_funct}, '0);

    // R-type sub, presented one cycle after acceptance.
    set_beat(1'b1, 2'b10, 6'b100010, 32'd7, 32'd3, 5'd9);
    step();
    chk("sub_ctrl", alu_ctrl, 3'b110);
    chk("sub_a", alu_a, 32'd7);
    chk("sub_b", alu_b, 32'd3);
    set_beat(1'b0, 2'b00, 6'd0, '0, '0, '0);
    step();

    // Back-pressure: three beats, only two fit, then in-order drain.
    out_ready = 1'b0;
    set_beat(1'b1, 2'b00, 6'd0, 32'h11, 32'h12, 5'd1);
    step();
    set_beat(1'b1, 2'b01, 6'd0, 32'h21, 32'h22, 5'd2);
    step();
    set_beat(1'b1, 2'b11, 6'd0, 32'h31, 32'h32, 5'd3);
    step();
    chk("full_rd_head", out_rd, 5'd1);
    set_beat(1'b0, 2'b00, 6'd0, '0, '0, '0);
    out_ready = 1'b1;
    step();
    chk("drain_rd_second", out_rd, 5'd2);
    step();

    // Illegal funct followed by an aluop-add beat.
    set_beat(1'b1, 2'b10, 6'b101010, 32'h5, 32'h6, 5'd4);
    step();
    chk("ill_ctrl", {alu_ctrl, ill_funct}, {3'b011, 1'b1});
    set_beat(1'b1, 2'b00, 6'b101010, 32'h7, 32'h8, 5'd5);
    step();
    chk("add_after_ill", {alu_ctrl, ill_funct}, {3'b010, 1'b0});
    set_beat(1'b0, 2'b00, 6'd0, '0, '0, '0);
    step();

    // Flush from TWO with a beat offered: everything dropped.
    out_ready = 1'b0;
    set_beat(1'b1, 2'b10, 6'b100100, 32'hA1, 32'hA2, 5'd6);
    step();
    set_beat(1'b1, 2'b10, 6'b100101, 32'hB1, 32'hB2, 5'd7);
    step();
    flush = 1'b1;
    set_beat(1'b1, 2'b10, 6'b100110, 32'hC1, 32'hC2, 5'd8);
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty", {out_valid, dbg_state}, 3'b000);
    set_beat(1'b0, 2'b00, 6'd0, '0, '0, '0);
    step();
    step();

    // Reset while one entry is buffered, with a beat offered.
    set_beat(1'b1, 2'b00, 6'd0, 32'hD1, 32'hD2, 5'd10);
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    set_beat(1'b1, 2'b01, 6'd0, 32'hE1, 32'hE2, 5'd11);
    step();
    rst = 1'b0;
    chk("rst_mid_zero", {out_valid, alu_ctrl, alu_a, alu_b, out_rd, ill_funct}, '0);
    out_ready = 1'b1;
    set_beat(1'b0, 2'b00, 6'd0, '0, '0, '0);
    step();

`ifdef ALU_ISSUE_FWD_EN
    // Forwarding to both operands, then fwd_rd=0 never substitutes.
    rs_a = 5'd5; rs_b = 5'd5; fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'hDEADBEEF;
    set_beat(1'b1, 2'b00, 6'd0, 32'h1, 32'h2, 5'd12);
    step();
    chk("fwd_ab", {alu_a, alu_b}, {32'hDEADBEEF, 32'hDEADBEEF});
    rs_a = 5'd0; rs_b = 5'd0; fwd_rd = 5'd0;
    set_beat(1'b1, 2'b00, 6'd0, 32'h3, 32'h4, 5'd13);
    step();
    chk("fwd_r0", {alu_a, alu_b}, {32'h3, 32'h4});
    fwd_valid = 1'b0;
    set_beat(1'b0, 2'b00, 6'd0, '0, '0, '0);
    step();
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set_beat($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
               ($urandom_range(0, 1) != 0) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom),
               $urandom, $urandom, 5'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 15) == 0;
      rst       = $urandom_range(0, 39) == 0;
`ifdef ALU_ISSUE_FWD_EN
      rs_a      = 5'($urandom_range(0, 3));
      rs_b      = 5'($urandom_range(0, 3));
      fwd_valid = $urandom_range(0, 1) != 0;
      fwd_rd    = 5'($urandom_range(0, 3));
      fwd_data  = $urandom;
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width.
REQ-002 SHALL have parameter: RD_W, 5, destination register index width.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have ports: in_valid in 1; in_ready out 1, i.e. the upstream (ID) beat handshake.
REQ-006 SHALL have ports: aluop in 2; funct in 6, i.e. the main-decoder ALU class and the R-type function field.
REQ-007 SHALL have ports: op_a in DATA_W; op_b in DATA_W; rd in RD_W, i.e. the operands and destination.
REQ-008 SHALL have port: flush  in  1  discard all buffered beats (branch/exception).
REQ-009 SHALL have ports: out_valid out 1; out_ready in 1, i.e. the downstream (EX) handshake.
REQ-010 SHALL have ports: alu_ctrl out 3; alu_a out DATA_W; alu_b out DATA_W; out_rd out RD_W, which drive the ALU ctrl/data1/data2 inputs.
REQ-011 SHALL have port: ill_funct  out  1  the presented beat carries an unsupported R-type funct.

Function
REQ-012 SHALL decode, at acceptance, aluop 00 -> alu_ctrl 010 (add), 01 -> 110 (sub), 11 -> 011 (pass data1), 10 -> by funct.
REQ-013 SHALL map funct 100000->010, 100010->110, 100100->000, 100101->001, 100110->111.
REQ-014 SHALL map any other funct under aluop 10 to alu_ctrl 011 with ill_funct=1; ill_funct SHALL be 0 for all other beats.
REQ-015 SHALL accept a beat when in_valid && in_ready, and SHALL register the decoded ctrl, op_a, op_b, rd and ill_funct together as one entry.
REQ-016 SHALL hold entries in a 2-entry in-order skid buffer with states EMPTY, ONE, TWO.
REQ-017 SHALL drive in_ready = (state != TWO) && !rst, with no combinational path from out_ready.
REQ-018 SHALL drive out_valid = (state != EMPTY); outputs SHALL show the oldest entry, stable while out_valid && !out_ready.
REQ-019 SHALL have a latency of one cycle: a beat accepted in EMPTY SHALL be presented on the next cycle.
REQ-020 SHALL take these transitions: EMPTY->ONE on accept; ONE->TWO on accept without pop; ONE->EMPTY on pop without accept; ONE->ONE on accept+pop; TWO->ONE on pop.
REQ-021 SHALL NOT accept in TWO, since in_ready=0.
REQ-022 SHALL make flush -> EMPTY next cycle, overriding any simultaneous accept or pop; the beat offered on the flush cycle SHALL be dropped.
REQ-023 SHALL hold payload outputs at last value while out_valid=0; consumers SHALL ignore them.

Reset
REQ-024 SHALL, with rst high, enter state EMPTY and clear all payload registers next edge: out_valid=0, alu_ctrl=000, alu_a=alu_b=0, out_rd=0, ill_funct=0.
REQ-025 SHALL keep in_ready 0 during any cycle rst is high; rst mid-transfer SHALL discard both entries identically to flush.

Configuration
REQ-026 SHALL use macro ALU_ISSUE_FWD_EN; defined: add ports rs_a in RD_W, rs_b in RD_W, fwd_valid in 1, fwd_rd in RD_W, fwd_data in DATA_W.
REQ-027 SHALL, with ALU_ISSUE_FWD_EN, replace op_a (op_b) with fwd_data at acceptance when fwd_valid && fwd_rd!=0 && fwd_rd==rs_a (rs_b); both operands may be replaced in the same beat.
REQ-028 SHALL, without ALU_ISSUE_FWD_EN, omit those ports and register op_a/op_b unmodified.

Structure
REQ-029 SHALL place the shared package alu_pkg with: ALU ctrl encodings (ADD, SUB, AND, OR, XOR, PASS), aluop codes, funct codes, and the skid-state typedef.
REQ-030 SHALL use one sub-module alu_ctrl_dec (combinational aluop/funct -> ctrl, ill_funct); the buffer/FSM SHALL be in alu_issue_ctrl.

Verification
REQ-031 SHALL check: aluop=10, funct=100010, op_a=7, op_b=3, out_ready=1 -> next cycle out_valid=1, alu_ctrl=110, alu_a=7, alu_b=3.
REQ-032 SHALL check: out_ready=0, three back-to-back beats -> first two accepted, in_ready=0 on third; then out_ready=1 -> in-order drain.
REQ-033 SHALL check: aluop=10, funct=101010 -> alu_ctrl=011, ill_funct=1; following aluop=00 beat -> alu_ctrl=010, ill_funct=0.
REQ-034 SHALL check: state TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, state EMPTY, offered beat never appears.
REQ-035 SHALL check: rst pulse while state ONE -> next cycle all outputs zero; during rst in_ready=0.
REQ-036 SHALL check (FWD_EN): rs_a=rs_b=5, fwd_valid=1, fwd_rd=5, fwd_data=0xDEADBEEF -> alu_a=alu_b=0xDEADBEEF; fwd_rd=0 -> no substitution.
